ymc_control: RTL and testbench
==============================

YMC_CONTROL -- requirements
Module: ymc_control

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning the width of the retired-instruction counter.
REQ-002 SHALL have parameter HAS_ANDOR, default 1; 1 enables decode of R-type AND (funct3 111) and SUB (funct3 000, funct7[5]=1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port ins, input, 32 bits: instruction word from yIF, sampled only in FETCH.
REQ-006 SHALL have port zero, input, 1 bit: ALU zero flag from yEX.
REQ-007 SHALL have port mem_ready, input, 1 bit: data memory handshake completion.
REQ-008 SHALL have port int_req, input, 1 bit: level interrupt request.
REQ-009 SHALL have outputs RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, isbranch, isjump, INT, each 1 bit, with yPC/yDM/yWB meanings.
REQ-010 SHALL have output op, 3 bits: ALU operation (010 add, 110 sub, 001 or, 000 and).
REQ-011 SHALL have outputs ir_we, 1 bit (instruction fetch strobe), and pc_we, 1 bit (PC update strobe).
REQ-012 SHALL have outputs state, 3 bits; retired, CNT_W bits; illegal, 1 bit.

Function
REQ-013 SHALL encode states BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, IRQ=6.
REQ-014 SHALL latch ins into an internal IR at the FETCH clock edge; decode SHALL use only the IR.
REQ-015 SHALL drive controls as Moore outputs of state plus IR; any output not listed for a state is 0, except ALUSrc=1 and op=010 by default.
REQ-016 BOOT: INT=1 and pc_we=1 for one cycle, then FETCH.
REQ-017 FETCH: ir_we=1, then DECODE.
REQ-018 DECODE: next state is EXEC for opcodes 0x33, 0x13, 0x03, 0x23, 0x63, 0x6F; for any other opcode, illegal=1 and pc_we=1 (instruction retires as a nop) and the instruction boundary is taken.
REQ-019 EXEC: R-type (0x33) sets ALUSrc=0; op=001 for funct3 110; op=000 for funct3 111 and op=110 for funct3 000 with funct7[5]=1, both only when HAS_ANDOR=1, else op=010.
REQ-020 EXEC: beq (0x63) sets ALUSrc=0, op=110, isbranch=1, pc_we=1; it is the boundary, latency 3 cycles.
REQ-021 EXEC transitions: lw/sw go to MEM; R, addi and jal go to WB.
REQ-022 MEM: lw sets MemRead=1, sw sets MemWrite=1, held until mem_ready=1; state stays MEM while mem_ready=0.
REQ-023 MEM with sw and mem_ready=1: pc_we=1; this is the boundary.
REQ-024 MEM with lw and mem_ready=1: next state is WB.
REQ-025 WB: RegWrite=1 and pc_we=1 (boundary); lw also sets Mem2Reg=1 and MemRead=1; jal sets isjump=1.
REQ-026 Latencies with zero wait: R/addi/jal 4 cycles, sw 4, lw 5, beq 3, illegal 2; each cycle of mem_ready=0 adds one cycle.
REQ-027 At each boundary cycle, retired SHALL increment by 1 modulo 2^CNT_W, wrapping from all-ones to 0.
REQ-028 At a boundary, if int_req=1, next state SHALL be IRQ, else FETCH; int_req outside boundary cycles SHALL be ignored.
REQ-029 IRQ: INT=1 and pc_we=1 for one cycle, then FETCH; the interrupted instruction's own writes SHALL complete unchanged.
REQ-030 illegal SHALL be a one-cycle pulse.

Reset
REQ-031 While rst_n=0 at a rising edge, the block SHALL set state to BOOT, clear IR, and clear retired to 0.
REQ-032 While rst_n=0, all strobes (ir_we, pc_we, RegWrite, MemRead, MemWrite, INT, isbranch, isjump) and illegal SHALL be forced to 0.
REQ-033 Reset asserted mid-instruction (including MEM wait) SHALL abandon the instruction without retiring it.

Verification
REQ-034 Reset release then ins=0x00500093 (addi) -> BOOT (INT=1, pc_we=1), FETCH, DECODE, EXEC (ALUSrc=1, op=010), WB (RegWrite=1); retired=1.
REQ-035 ins=0x0020E1B3 (or) -> EXEC op=001, ALUSrc=0; ins=0x0020F1B3 (and) -> op=000; with HAS_ANDOR=0 -> op=010.
REQ-036 ins=0x0000A103 (lw), mem_ready low for 2 cycles -> MemRead=1 for 3 MEM cycles, then WB with Mem2Reg=1, RegWrite=1; total latency 7 cycles.
REQ-037 ins=0x00208463 (beq) -> EXEC isbranch=1, op=110, pc_we=1, RegWrite=0; ins=0x008000EF (jal) -> WB isjump=1, RegWrite=1.
REQ-038 int_req=1 during sw (0x0020A223) boundary -> IRQ cycle (INT=1, pc_we=1) then FETCH; retired increments once; CNT_W=4 with 16 retirements -> retired wraps to 0.
REQ-039 ins=0x0000007F -> DECODE illegal=1, pc_we=1, no RegWrite/MemWrite; rst_n=0 during MEM wait -> BOOT, retired=0.

Source files
------------

// File: rtl/ymc_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ymc_control
// Brief    : Multi-cycle control FSM for the yMC RISC-V datapath.
// Revision : 1.0 - initial release
// ============================================================================
module ymc_control #(
   parameter int CNT_W     = 16,
   parameter int HAS_ANDOR = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      ins,
   input  logic             zero,
   input  logic             mem_ready,
   input  logic             int_req,
   output logic             RegWrite,
   output logic             ALUSrc,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             Mem2Reg,
   output logic             isbranch,
   output logic             isjump,
   output logic             INT,
   output logic [2:0]       op,
   output logic             ir_we,
   output logic             pc_we,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired,
   output logic             illegal
);

   localparam logic [2:0] c_BOOT   = 3'd0;
   localparam logic [2:0] c_FETCH  = 3'd1;
   localparam logic [2:0] c_DECODE = 3'd2;
   localparam logic [2:0] c_EXEC   = 3'd3;
   localparam logic [2:0] c_MEM    = 3'd4;
   localparam logic [2:0] c_WB     = 3'd5;
   localparam logic [2:0] c_IRQ    = 3'd6;

   localparam logic [6:0] c_OP_R   = 7'h33;
   localparam logic [6:0] c_OP_I   = 7'h13;
   localparam logic [6:0] c_OP_LW  = 7'h03;
   localparam logic [6:0] c_OP_SW  = 7'h23;
   localparam logic [6:0] c_OP_BEQ = 7'h63;
   localparam logic [6:0] c_OP_JAL = 7'h6F;

   localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [2:0]       r_state;
   logic [31:0]      r_ir;
   logic [CNT_W-1:0] r_retired;

   logic [2:0] w_next;
   logic [2:0] w_rop;
   logic [2:0] w_op;
   logic [2:0] w_f3;
   logic [6:0] w_opc;
   logic       w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_beq, w_is_jal, w_legal;
   logic       w_boundary;
   logic       w_regwrite, w_alusrc, w_memread, w_memwrite, w_mem2reg;
   logic       w_isbranch, w_isjump, w_int, w_ir_we, w_pc_we, w_illegal;
   logic       w_unused;

   assign w_opc    = r_ir[6:0];
   assign w_f3     = r_ir[14:12];
   assign w_is_r   = (w_opc == c_OP_R);
   assign w_is_i   = (w_opc == c_OP_I);
   assign w_is_lw  = (w_opc == c_OP_LW);
   assign w_is_sw  = (w_opc == c_OP_SW);
   assign w_is_beq = (w_opc == c_OP_BEQ);
   assign w_is_jal = (w_opc == c_OP_JAL);
   assign w_legal  = w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_beq | w_is_jal;

   // The branch decision is taken in the PC mux from isbranch and zero.
   assign w_unused = ^{zero, r_ir};

   always_comb begin
      w_rop = 3'b010;
      if (w_f3 == 3'b110) begin
         w_rop = 3'b001;
      end else if ((HAS_ANDOR != 0) && (w_f3 == 3'b111)) begin
         w_rop = 3'b000;
      end else if ((HAS_ANDOR != 0) && (w_f3 == 3'b000) && r_ir[30]) begin
         w_rop = 3'b110;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_boundary = 1'b0;
      w_regwrite = 1'b0;
      w_alusrc   = 1'b1;
      w_memread  = 1'b0;
      w_memwrite = 1'b0;
      w_mem2reg  = 1'b0;
      w_isbranch = 1'b0;
      w_isjump   = 1'b0;
      w_int      = 1'b0;
      w_ir_we    = 1'b0;
      w_pc_we    = 1'b0;
      w_illegal  = 1'b0;
      w_op       = 3'b010;
      case (r_state)
         c_BOOT: begin
            w_int   = 1'b1;
            w_pc_we = 1'b1;
            w_next  = c_FETCH;
         end
         c_FETCH: begin
            w_ir_we = 1'b1;
            w_next  = c_DECODE;
         end
         c_DECODE: begin
            if (w_legal) begin
               w_next = c_EXEC;
            end else begin
               w_illegal  = 1'b1;
               w_pc_we    = 1'b1;
               w_boundary = 1'b1;
            end
         end
         c_EXEC: begin
            if (w_is_beq) begin
               w_alusrc   = 1'b0;
               w_op       = 3'b110;
               w_isbranch = 1'b1;
               w_pc_we    = 1'b1;
               w_boundary = 1'b1;
            end else if (w_is_lw || w_is_sw) begin
               w_next = c_MEM;
            end else begin
               if (w_is_r) begin
                  w_alusrc = 1'b0;
                  w_op     = w_rop;
               end
               w_next = c_WB;
            end
         end
         c_MEM: begin
            w_memread  = w_is_lw;
            w_memwrite = w_is_sw;
            if (mem_ready) begin
               if (w_is_sw) begin
                  w_pc_we    = 1'b1;
                  w_boundary = 1'b1;
               end else begin
                  w_next = c_WB;
               end
            end
         end
         c_WB: begin
            w_regwrite = 1'b1;
            w_pc_we    = 1'b1;
            w_mem2reg  = w_is_lw;
            w_memread  = w_is_lw;
            w_isjump   = w_is_jal;
            w_boundary = 1'b1;
         end
         c_IRQ: begin
            w_int   = 1'b1;
            w_pc_we = 1'b1;
            w_next  = c_FETCH;
         end
         default: w_next = c_BOOT;
      endcase
      // Interrupts are only honoured between instructions.
      if (w_boundary) begin
         w_next = int_req ? c_IRQ : c_FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= c_BOOT;
         r_ir      <= '0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == c_FETCH) begin
            r_ir <= ins;
         end
         if (w_boundary) begin
            r_retired <= r_retired + c_ONE;
         end
      end
   end

   assign RegWrite = w_regwrite & rst_n;
   assign ALUSrc   = w_alusrc;
   assign MemRead  = w_memread  & rst_n;
   assign MemWrite = w_memwrite & rst_n;
   assign Mem2Reg  = w_mem2reg;
   assign isbranch = w_isbranch & rst_n;
   assign isjump   = w_isjump   & rst_n;
   assign INT      = w_int      & rst_n;
   assign op       = w_op;
   assign ir_we    = w_ir_we    & rst_n;
   assign pc_we    = w_pc_we    & rst_n;
   assign illegal  = w_illegal  & rst_n;
   assign state    = r_state;
   assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_ymc_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ymc_control
// Brief    : Self-checking bench for ymc_control (table, random and corner runs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ymc_control;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] ins = '0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        int_req = 1'b0;

   // Packed as {state, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, isbranch, isjump, INT, op, ir_we, pc_we, illegal}
   wire [16:0] o0, o1, o2;
   wire [15:0] ret0, ret1;
   wire [3:0]  ret2;

   always #5 clk = ~clk;

   ymc_control #(.CNT_W(16), .HAS_ANDOR(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .ins(ins), .zero(zero), .mem_ready(mem_ready), .int_req(int_req),
      .RegWrite(o0[13]), .ALUSrc(o0[12]), .MemRead(o0[11]), .MemWrite(o0[10]), .Mem2Reg(o0[9]),
      .isbranch(o0[8]), .isjump(o0[7]), .INT(o0[6]), .op(o0[5:3]), .ir_we(o0[2]), .pc_we(o0[1]),
      .state(o0[16:14]), .retired(ret0), .illegal(o0[0]));

   ymc_control #(.CNT_W(16), .HAS_ANDOR(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ins(ins), .zero(zero), .mem_ready(mem_ready), .int_req(int_req),
      .RegWrite(o1[13]), .ALUSrc(o1[12]), .MemRead(o1[11]), .MemWrite(o1[10]), .Mem2Reg(o1[9]),
      .isbranch(o1[8]), .isjump(o1[7]), .INT(o1[6]), .op(o1[5:3]), .ir_we(o1[2]), .pc_we(o1[1]),
      .state(o1[16:14]), .retired(ret1), .illegal(o1[0]));

   ymc_control #(.CNT_W(4), .HAS_ANDOR(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .ins(ins), .zero(zero), .mem_ready(mem_ready), .int_req(int_req),
      .RegWrite(o2[13]), .ALUSrc(o2[12]), .MemRead(o2[11]), .MemWrite(o2[10]), .Mem2Reg(o2[9]),
      .isbranch(o2[8]), .isjump(o2[7]), .INT(o2[6]), .op(o2[5:3]), .ir_we(o2[2]), .pc_we(o2[1]),
      .state(o2[16:14]), .retired(ret2), .illegal(o2[0]));

   typedef struct packed {
      logic [2:0] st;
      logic       rw, as, mr, mw, m2r, br, jp, intr;
      logic [2:0] op;
      logic       irwe, pcwe, ill;
   } ev_t;

   typedef struct {
      ev_t  e0;
      ev_t  e1;
      bit   mcare;
      logic mr;
      bit   bnd;
   } st_t;

   typedef struct {
      logic [31:0] ins;
      int          waits;
      bit          irq;
      int          lat;
      logic [2:0]  op_a;
      logic [2:0]  op_n;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned cnt     = 0;
   st_t         tr[$];
   vec_t        tbl[11];

   function automatic ev_t base(input logic [2:0] st);
      ev_t e = '0;
      e.st = st;
      e.as = 1'b1;
      e.op = 3'b010;
      return e;
   endfunction

   // 0 R, 1 addi, 2 lw, 3 sw, 4 beq, 5 jal, 6 illegal
   function automatic int kind(input logic [31:0] i);
      case (i[6:0])
         7'h33:   return 0;
         7'h13:   return 1;
         7'h03:   return 2;
         7'h23:   return 3;
         7'h63:   return 4;
         7'h6F:   return 5;
         default: return 6;
      endcase
   endfunction

   function automatic logic [2:0] rop(input logic [31:0] i, input bit andor);
      if (i[14:12] == 3'b110) return 3'b001;
      if (andor && i[14:12] == 3'b111) return 3'b000;
      if (andor && i[14:12] == 3'b000 && i[30]) return 3'b110;
      return 3'b010;
   endfunction

   function automatic int exp_lat(input logic [31:0] i, input int waits);
      case (kind(i))
         2:       return 5 + waits;
         3:       return 4 + waits;
         4:       return 3;
         6:       return 2;
         default: return 4;
      endcase
   endfunction

   // Expected cycle-by-cycle trace of one instruction, built from the instruction class.
   task automatic build(input logic [31:0] i, input int waits, input bit irq);
      st_t s;
      ev_t e;
      int  k = kind(i);
      tr.delete();
      s.mcare = 0; s.mr = 1'b0; s.bnd = 0;
      e = base(3'd1); e.irwe = 1'b1;
      s.e0 = e; s.e1 = e; tr.push_back(s);
      e = base(3'd2);
      if (k == 6) begin e.ill = 1'b1; e.pcwe = 1'b1; s.bnd = 1; end
      s.e0 = e; s.e1 = e; tr.push_back(s);
      if (k != 6) begin
         s.bnd = 0;
         e = base(3'd3);
         if (k == 4) begin
            e.as = 1'b0; e.op = 3'b110; e.br = 1'b1; e.pcwe = 1'b1; s.bnd = 1;
         end
         s.e0 = e; s.e1 = e;
         if (k == 0) begin
            s.e0.as = 1'b0; s.e0.op = rop(i, 1'b1);
            s.e1.as = 1'b0; s.e1.op = rop(i, 1'b0);
         end
         tr.push_back(s);
         if (k == 2 || k == 3) begin
            for (int w = 0; w <= waits; w++) begin
               e = base(3'd4);
               e.mr = (k == 2); e.mw = (k == 3);
               s.mcare = 1; s.mr = (w == waits); s.bnd = 0;
               if (k == 3 && w == waits) begin e.pcwe = 1'b1; s.bnd = 1; end
               s.e0 = e; s.e1 = e; tr.push_back(s);
            end
            s.mcare = 0;
         end
         if (k == 0 || k == 1 || k == 2 || k == 5) begin
            e = base(3'd5);
            e.rw = 1'b1; e.pcwe = 1'b1;
            e.m2r = (k == 2); e.mr = (k == 2); e.jp = (k == 5);
            s.bnd = 1; s.e0 = e; s.e1 = e; tr.push_back(s);
         end
      end
      if (irq) begin
         e = base(3'd6); e.intr = 1'b1; e.pcwe = 1'b1;
         s.bnd = 0; s.mcare = 0; s.e0 = e; s.e1 = e; tr.push_back(s);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic [31:0] i, input logic mr, input logic ir, input logic rn);
      @(posedge clk);
      #1;
      ins = i; mem_ready = mr; int_req = ir; rst_n = rn;
      #1;
   endtask

   task automatic boot_check();
      ev_t e = base(3'd0);
      e.intr = 1'b1; e.pcwe = 1'b1;
      rst_n = 1'b1;
      #1;
      chk("boot_outs", 32'(o0), 32'(e));
      chk("boot_outs_noandor", 32'(o1), 32'(e));
      chk("boot_outs_cnt4", 32'(o2), 32'(e));
      cnt = 0;
   endtask

   task automatic run(input logic [31:0] i, input int waits, input bit irq, input int lat,
                      input logic [2:0] opa, input logic [2:0] opn, input bit chk_op);
      int         seen = 0;
      logic [2:0] sa = 3'b111;
      logic [2:0] sn = 3'b111;
      build(i, waits, irq);
      foreach (tr[j]) begin
         step((j == 0) ? i : $urandom,
              tr[j].mcare ? tr[j].mr : 1'($urandom),
              tr[j].bnd ? irq : 1'($urandom), 1'b1);
         chk("outs_andor", 32'(o0), 32'(tr[j].e0));
         chk("outs_noandor", 32'(o1), 32'(tr[j].e1));
         chk("outs_cnt4", 32'(o2), 32'(tr[j].e0));
         chk("retired", 32'(ret0), 32'(cnt[15:0]));
         chk("retired_noandor", 32'(ret1), 32'(cnt[15:0]));
         chk("retired_cnt4", 32'(ret2), 32'(cnt[3:0]));
         if (seen == 0 && o0[1] && (o0[16:14] inside {3'd2, 3'd3, 3'd4, 3'd5})) seen = j + 1;
         if (o0[16:14] == 3'd3) sa = o0[5:3];
         if (o1[16:14] == 3'd3) sn = o1[5:3];
         if (tr[j].bnd) cnt++;
      end
      chk("latency", 32'(seen), 32'(lat));
      if (chk_op) begin
         chk("exec_op", 32'(sa), 32'(opa));
         chk("exec_op_noandor", 32'(sn), 32'(opn));
      end
   endtask

   initial begin
      logic [31:0] ri;
      ev_t         e;
      int          w;
      bit          q;

      tbl[0]  = '{32'h00500093, 0, 0, 4, 3'b010, 3'b010};  // addi
      tbl[1]  = '{32'h0020E1B3, 0, 0, 4, 3'b001, 3'b001};  // or
      tbl[2]  = '{32'h0020F1B3, 0, 0, 4, 3'b000, 3'b010};  // and
      tbl[3]  = '{32'h40208133, 0, 0, 4, 3'b110, 3'b010};  // sub
      tbl[4]  = '{32'h0000A103, 2, 0, 7, 3'b010, 3'b010};  // lw, 2 waits
      tbl[5]  = '{32'h00208463, 0, 0, 3, 3'b110, 3'b110};  // beq
      tbl[6]  = '{32'h008000EF, 0, 0, 4, 3'b010, 3'b010};  // jal
      tbl[7]  = '{32'h0020A223, 0, 1, 4, 3'b010, 3'b010};  // sw + irq
      tbl[8]  = '{32'h0000007F, 0, 0, 2, 3'b111, 3'b111};  // illegal, no EXEC
      tbl[9]  = '{32'h0000A103, 0, 0, 5, 3'b010, 3'b010};  // lw, no wait
      tbl[10] = '{32'h0020A223, 1, 0, 5, 3'b010, 3'b010};  // sw, 1 wait

      repeat (2) @(posedge clk);
      #2;
      chk("reset_outs", 32'(o0), 32'(base(3'd0)));
      chk("reset_retired", 32'(ret0), 32'd0);
      chk("reset_retired_cnt4", 32'(ret2), 32'd0);
      boot_check();

      for (int t = 0; t < 11; t++)
         run(tbl[t].ins, tbl[t].waits, tbl[t].irq, tbl[t].lat, tbl[t].op_a, tbl[t].op_n, 1'b1);

      for (int r = 0; r < 40; r++) begin
         ri = $urandom;
         case ($urandom_range(0, 6))
            0: ri[6:0] = 7'h33;
            1: ri[6:0] = 7'h13;
            2: ri[6:0] = 7'h03;
            3: ri[6:0] = 7'h23;
            4: ri[6:0] = 7'h63;
            5: ri[6:0] = 7'h6F;
            default: if (kind(ri) != 6) ri[6:0] = 7'h0B;
         endcase
         w = $urandom_range(0, 3);
         q = ($urandom_range(0, 3) == 0);
         run(ri, w, q, exp_lat(ri, w), 3'b000, 3'b000, 1'b0);
      end

      // Reset while a load waits on memory: abandoned, never retired.
      step(32'h0000A103, 1'b0, 1'b0, 1'b1);
      chk("abort_fetch_state", 32'(o0[16:14]), 32'd1);
      step($urandom, 1'b0, 1'b0, 1'b1);
      step($urandom, 1'b0, 1'b0, 1'b1);
      step($urandom, 1'b0, 1'b0, 1'b1);
      e = base(3'd4); e.mr = 1'b1;
      chk("mem_wait_read", 32'(o0), 32'(e));
      step($urandom, 1'b0, 1'b0, 1'b0);
      chk("reset_in_mem_forced", 32'(o0), 32'(base(3'd4)));
      step($urandom, 1'b0, 1'b1, 1'b0);
      chk("reset_to_boot", 32'(o0), 32'(base(3'd0)));
      chk("reset_abort_retired", 32'(ret0), 32'd0);
      chk("reset_abort_retired_cnt4", 32'(ret2), 32'd0);
      boot_check();

      // Sixteen retirements wrap the 4-bit counter back to zero.
      for (int t = 0; t < 16; t++)
         run(tbl[t % 11].ins, tbl[t % 11].waits, tbl[t % 11].irq, tbl[t % 11].lat,
             tbl[t % 11].op_a, tbl[t % 11].op_n, 1'b1);
      @(posedge clk);
      #2;
      chk("wrap_cnt4", 32'(ret2), 32'd0);
      chk("retired_16", 32'(ret0), 32'd16);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
